// File: rtl/si_aliens_march_ctrl.sv
// ---------------------------------------------------------------------------
// si_aliens_march_ctrl
//
// Purpose:
//   Sequencer for the alien formation. It times each march step, decides
//   whether the formation moves sideways or drops one row, clears the alien
//   register bank when a wave starts, and reports wave completion and
//   game over.
//
// Ports:
//   ALIENS_MARCH_CLOCK_50              in   system clock, rising edge
//   ALIENS_MARCH_RESET_InHigh          in   synchronous reset, active high
//   ALIENS_MARCH_Start_In              in   one-cycle wave start request
//   ALIENS_MARCH_Pause_In              in   freezes the step timer while high
//   ALIENS_MARCH_ColOcc_InBus[7:0]     in   column occupancy, bit 7 = leftmost
//   ALIENS_MARCH_BottomHit_In          in   an alien reached the bottom row
//   ALIENS_MARCH_shiftselection_OutBus out  00 hold, 01 left, 10 right
//   ALIENS_MARCH_Load_OutLow           out  active-low pulse: move rows down
//   ALIENS_MARCH_Clear_OutLow          out  active-low pulse: clear the bank
//   ALIENS_MARCH_Busy_Out              out  high while a wave is running
//   ALIENS_MARCH_WaveDone_Out          out  one-cycle pulse, all aliens gone
//   ALIENS_MARCH_GameOver_Out          out  held high in the game-over state
// ---------------------------------------------------------------------------
module si_aliens_march_ctrl #(
    parameter int STEP_PERIOD = 25000000,
    parameter int STEP_DEC    = 1000000,
    parameter int MIN_PERIOD  = 5000000,
    parameter int CNT_W       = 25
) (
    input  logic       ALIENS_MARCH_CLOCK_50,
    input  logic       ALIENS_MARCH_RESET_InHigh,
    input  logic       ALIENS_MARCH_Start_In,
    input  logic       ALIENS_MARCH_Pause_In,
    input  logic [7:0] ALIENS_MARCH_ColOcc_InBus,
    input  logic       ALIENS_MARCH_BottomHit_In,
    output logic [1:0] ALIENS_MARCH_shiftselection_OutBus,
    output logic       ALIENS_MARCH_Load_OutLow,
    output logic       ALIENS_MARCH_Clear_OutLow,
    output logic       ALIENS_MARCH_Busy_Out,
    output logic       ALIENS_MARCH_WaveDone_Out,
    output logic       ALIENS_MARCH_GameOver_Out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_DECIDE,
        ST_HSTEP,
        ST_DOWN,
        ST_OVER
    } state_t;

    localparam logic [CNT_W-1:0] STEP_PERIOD_C = CNT_W'(STEP_PERIOD);
    localparam logic [CNT_W-1:0] STEP_DEC_C    = CNT_W'(STEP_DEC);
    localparam logic [CNT_W-1:0] MIN_PERIOD_C  = CNT_W'(MIN_PERIOD);
    // One extra bit so MIN_PERIOD + STEP_DEC cannot overflow the compare.
    localparam logic [CNT_W:0]   DEC_FLOOR_C   = (CNT_W+1)'(MIN_PERIOD) + (CNT_W+1)'(STEP_DEC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             dir_right_q, dir_right_d;
    logic [1:0]       shift_q, shift_d;
    logic             load_n_q, load_n_d;
    logic             clear_n_q, clear_n_d;
    logic             busy_q, busy_d;
    logic             wave_done_q, wave_done_d;
    logic             game_over_q, game_over_d;

    // Next-state logic. Outputs are derived from the state being entered so
    // that, once registered, each pulse lines up with the cycle spent in its
    // own state (CLEAR, HSTEP, DOWN).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        dir_right_d = dir_right_q;
        wave_done_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (ALIENS_MARCH_Start_In) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                dir_right_d = 1'b1;
                period_d    = STEP_PERIOD_C;
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (!ALIENS_MARCH_Pause_In) begin
                    if (cnt_q == period_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_DECIDE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DECIDE: begin
                // Bottom hit wins over an empty board: no WaveDone then.
                if (ALIENS_MARCH_BottomHit_In) begin
                    state_d = ST_OVER;
                end else if (ALIENS_MARCH_ColOcc_InBus == 8'h00) begin
                    state_d     = ST_IDLE;
                    wave_done_d = 1'b1;
                end else if (( dir_right_q && ALIENS_MARCH_ColOcc_InBus[0]) ||
                             (!dir_right_q && ALIENS_MARCH_ColOcc_InBus[7])) begin
                    state_d = ST_DOWN;
                end else begin
                    state_d = ST_HSTEP;
                end
            end
            ST_HSTEP: begin
                state_d = ST_WAIT;
            end
            ST_DOWN: begin
                dir_right_d = !dir_right_q;
                // Saturate at MIN_PERIOD without ever letting the subtract wrap.
                if ({1'b0, period_q} >= DEC_FLOOR_C) begin
                    period_d = period_q - STEP_DEC_C;
                end else begin
                    period_d = MIN_PERIOD_C;
                end
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Direction never changes on the way into HSTEP, so the current
        // direction selects the shift code.
        if (state_d == ST_HSTEP) begin
            shift_d = dir_right_q ? 2'b10 : 2'b01;
        end else begin
            shift_d = 2'b00;
        end
        load_n_d    = (state_d != ST_DOWN);
        clear_n_d   = (state_d != ST_CLEAR);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_OVER);
        game_over_d = (state_d == ST_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ALIENS_MARCH_CLOCK_50) begin
        if (ALIENS_MARCH_RESET_InHigh) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= STEP_PERIOD_C;
            dir_right_q <= 1'b1;
            shift_q     <= 2'b00;
            load_n_q    <= 1'b1;
            clear_n_q   <= 1'b1;
            busy_q      <= 1'b0;
            wave_done_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            dir_right_q <= dir_right_d;
            shift_q     <= shift_d;
            load_n_q    <= load_n_d;
            clear_n_q   <= clear_n_d;
            busy_q      <= busy_d;
            wave_done_q <= wave_done_d;
            game_over_q <= game_over_d;
        end
    end

    assign ALIENS_MARCH_shiftselection_OutBus = shift_q;
    assign ALIENS_MARCH_Load_OutLow           = load_n_q;
    assign ALIENS_MARCH_Clear_OutLow          = clear_n_q;
    assign ALIENS_MARCH_Busy_Out              = busy_q;
    assign ALIENS_MARCH_WaveDone_Out          = wave_done_q;
    assign ALIENS_MARCH_GameOver_Out          = game_over_q;

endmodule

// File: tb/tb_si_aliens_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_si_aliens_march_ctrl
//
// Drives directed scenarios followed by random traffic into the march
// controller. For every clock edge the stimulus side runs a behavioural game
// model and queues the outputs it expects after that edge; an independent
// monitor pops each entry half a cycle after its edge and compares.
// ---------------------------------------------------------------------------
module tb_si_aliens_march_ctrl;

    localparam int SP = 4;
    localparam int SD = 1;
    localparam int MP = 2;
    localparam int CW = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] colOcc = 8'h00;
    logic       bottomHit = 1'b0;

    logic [1:0] shiftSel;
    logic       loadN;
    logic       clearN;
    logic       busy;
    logic       waveDone;
    logic       gameOver;

    // 100 MHz-style free running clock for the bench.
    always #5 clock = ~clock;

    si_aliens_march_ctrl #(
        .STEP_PERIOD(SP),
        .STEP_DEC(SD),
        .MIN_PERIOD(MP),
        .CNT_W(CW)
    ) dut (
        .ALIENS_MARCH_CLOCK_50(clock),
        .ALIENS_MARCH_RESET_InHigh(reset),
        .ALIENS_MARCH_Start_In(start),
        .ALIENS_MARCH_Pause_In(pause),
        .ALIENS_MARCH_ColOcc_InBus(colOcc),
        .ALIENS_MARCH_BottomHit_In(bottomHit),
        .ALIENS_MARCH_shiftselection_OutBus(shiftSel),
        .ALIENS_MARCH_Load_OutLow(loadN),
        .ALIENS_MARCH_Clear_OutLow(clearN),
        .ALIENS_MARCH_Busy_Out(busy),
        .ALIENS_MARCH_WaveDone_Out(waveDone),
        .ALIENS_MARCH_GameOver_Out(gameOver)
    );

    typedef struct {
        int         cycle;
        logic [1:0] shift;
        logic       loadN;
        logic       clearN;
        logic       busy;
        logic       waveDone;
        logic       gameOver;
    } expect_t;

    expect_t expQ[$];
    expect_t lastExp;
    int      edgeCount = 0;
    int      checks = 0;
    int      passes = 0;

    // Game model: is a wave running, did the last one end at the bottom,
    // the current step period, marching direction, unpaused wait cycles
    // elapsed, and what the next edge does (0 waiting, 1 decision due,
    // 2 leaving a one-cycle pulse).
    bit mActive  = 1'b0;
    bit mOver    = 1'b0;
    int mPeriod  = SP;
    bit mRight   = 1'b1;
    int mElapsed = 0;
    int mPhase   = 0;

    // Edge counter used to tag expectations with the edge they belong to.
    always @(posedge clock) edgeCount <= edgeCount + 1;

    // Advance the game model by one clock edge with the given inputs and
    // report the outputs the controller should show after that edge.
    task automatic modelEdge(input bit r, input bit s, input bit p,
                             input logic [7:0] c, input bit b,
                             output expect_t e);
        e.shift    = 2'b00;
        e.loadN    = 1'b1;
        e.clearN   = 1'b1;
        e.waveDone = 1'b0;
        if (r) begin
            mActive  = 1'b0;
            mOver    = 1'b0;
            mPeriod  = SP;
            mRight   = 1'b1;
            mElapsed = 0;
            mPhase   = 0;
        end else if (!mActive) begin
            if (s) begin
                mActive  = 1'b1;
                mOver    = 1'b0;
                mRight   = 1'b1;
                mPeriod  = SP;
                mElapsed = 0;
                mPhase   = 2;
                e.clearN = 1'b0;
            end
        end else begin
            case (mPhase)
                2: begin
                    mPhase   = 0;
                    mElapsed = 0;
                end
                0: begin
                    if (!p) begin
                        mElapsed++;
                        if (mElapsed == mPeriod) begin
                            mElapsed = 0;
                            mPhase   = 1;
                        end
                    end
                end
                default: begin
                    if (b) begin
                        mActive = 1'b0;
                        mOver   = 1'b1;
                    end else if (c == 8'h00) begin
                        mActive    = 1'b0;
                        e.waveDone = 1'b1;
                    end else if ((mRight && c[0]) || (!mRight && c[7])) begin
                        e.loadN = 1'b0;
                        mRight  = !mRight;
                        mPeriod = (mPeriod - SD > MP) ? mPeriod - SD : MP;
                        mPhase  = 2;
                    end else begin
                        e.shift = mRight ? 2'b10 : 2'b01;
                        mPhase  = 2;
                    end
                end
            endcase
        end
        e.busy     = mActive;
        e.gameOver = mOver && !mActive;
    endtask

    // Drive one cycle of inputs shortly after a rising edge so they are
    // stable for the next edge, and queue what that edge should produce.
    task automatic applyStimulus(input bit r, input bit s, input bit p,
                                 input logic [7:0] c, input bit b);
        expect_t e;
        @(posedge clock);
        #1;
        reset     = r;
        start     = s;
        pause     = p;
        colOcc    = c;
        bottomHit = b;
        modelEdge(r, s, p, c, b, e);
        e.cycle = edgeCount + 1;
        lastExp = e;
        expQ.push_back(e);
    endtask

    task automatic runCycles(input int n, input logic [7:0] c);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, c, 1'b0);
    endtask

    // Compare one queued expectation against the outputs the DUT shows now.
    task automatic checkOutput(input expect_t e);
        checks++;
        if (shiftSel === e.shift && loadN === e.loadN && clearN === e.clearN &&
            busy === e.busy && waveDone === e.waveDone && gameOver === e.gameOver) begin
            passes++;
        end else begin
            $display("[TB] FAIL outputs at edge %0d: got shift=%b load_n=%b clear_n=%b busy=%b wave_done=%b game_over=%b, expected shift=%b load_n=%b clear_n=%b busy=%b wave_done=%b game_over=%b",
                     e.cycle, shiftSel, loadN, clearN, busy, waveDone, gameOver,
                     e.shift, e.loadN, e.clearN, e.busy, e.waveDone, e.gameOver);
        end
    endtask

    // Monitor: on each falling edge, pop the expectation tagged with the
    // edge that just happened and check it.
    always @(negedge clock) begin
        if (expQ.size() > 0 && expQ[0].cycle == edgeCount) begin
            checkOutput(expQ.pop_front());
        end
    end

    // Stimulus: directed scenarios first, then random traffic.
    initial begin
        bit hitShift;

        $display("[TB] reset and first wave, marching right");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        runCycles(20, 8'h3C);

        $display("[TB] right edge reached, drop and reverse");
        runCycles(16, 8'h01);

        $display("[TB] repeated drops down to the period floor");
        runCycles(40, 8'h81);

        $display("[TB] pause in the middle of a wait");
        runCycles(3, 8'h3C);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        runCycles(12, 8'h3C);

        $display("[TB] bottom hit with empty board, then restart and clear wave");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        runCycles(4, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        runCycles(3, 8'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        runCycles(12, 8'h00);

        $display("[TB] reset during a horizontal step");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        hitShift = 1'b0;
        for (int i = 0; i < 40 && !hitShift; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
            hitShift = (lastExp.shift != 2'b00);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
        runCycles(2, 8'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        runCycles(15, 8'h3C);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] c;
            case ($urandom_range(0, 9))
                0:       c = 8'h00;
                1:       c = 8'h01;
                2:       c = 8'h80;
                default: c = 8'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 399) == 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 4) == 0),
                          c,
                          ($urandom_range(0, 59) == 0));
        end

        // Let the last queued expectations drain, then confirm none remain.
        runCycles(2, 8'h3C);
        repeat (3) @(negedge clock);
        checks++;
        if (expQ.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
